// File: rtl/synth_pkg.sv
// synth_pkg: shared FSM state type, MIDI note width and slot-width helper for the voice allocator.
package synth_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  localparam int NOTE_W = 7;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/voice_lru.sv
// voice_lru: age permutation per voice (0 = newest); reports the oldest voice index.
module voice_lru
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  localparam int SW = clog2(NUM_VOICES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc,
  input  logic [SW-1:0] alloc_idx,
  output logic [SW-1:0] oldest
);
  logic [SW-1:0] age [NUM_VOICES];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) age[i] <= SW'(i);
    end else if (alloc) begin
      for (int i = 0; i < NUM_VOICES; i++)
        age[i] <= (SW'(i) == alloc_idx) ? '0 : (age[i] < age[alloc_idx]) ? age[i] + 1'b1 : age[i];
    end
  end
  always_comb begin
    oldest = '0;
    for (int i = 0; i < NUM_VOICES; i++) if (age[i] == SW'(NUM_VOICES - 1)) oldest = SW'(i);
  end
endmodule

// File: rtl/tdm_voice_alloc.sv
// tdm_voice_alloc: TDM phase-accumulator voice bank with a scanning note allocator.
// Define VOICE_STEAL_EN to steal the oldest voice when the pool is full instead of dropping the note.
module tdm_voice_alloc
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ACC_W = 24,
  parameter int INC_W = 16,
  parameter int ADDR_W = 8,
  parameter int WAVE_W = 2,
  localparam int SW = clog2(NUM_VOICES)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  note_on_stb,
  input  logic                  note_off_stb,
  input  logic [NOTE_W-1:0]     note_num,
  input  logic [INC_W-1:0]      note_inc,
  input  logic [WAVE_W-1:0]     note_wave,
  output logic                  cmd_ready,
  output logic                  drop_stb,
  output logic [NUM_VOICES-1:0] voices_active,
  output logic [SW-1:0]         tdm_voice_num,
  output logic [ADDR_W-1:0]     tdm_addr,
  output logic [WAVE_W-1:0]     tdm_wavesel,
  output logic                  tdm_voice_en,
  output logic                  tdm_frame_start
);
  logic rst_n;
  state_t state, state_d;
  logic [SW-1:0] slot, scan_idx, hit_idx, free_idx, oldest, tgt;
  logic hit, free, cmd_on, tgt_ok, alloc, off, commit;
  logic [NOTE_W-1:0] cmd_note;
  logic [INC_W-1:0] cmd_inc;
  logic [WAVE_W-1:0] cmd_wave;
  logic [NUM_VOICES-1:0] active;
  logic [ACC_W-1:0] acc [NUM_VOICES];
  logic [INC_W-1:0] inc [NUM_VOICES];
  logic [WAVE_W-1:0] wave [NUM_VOICES];
  logic [NOTE_W-1:0] note [NUM_VOICES];
  logic [ACC_W-1:0] upd;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_n <= 1'b0;
    else rst_n <= 1'b1;
  end
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (note_on_stb || note_off_stb) state_d = SCAN;
      SCAN:    if (scan_idx == SW'(NUM_VOICES - 1)) state_d = COMMIT;
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready = (state == IDLE);
  assign commit = (state == COMMIT);
  assign tgt = hit ? hit_idx : free ? free_idx : oldest;
`ifdef VOICE_STEAL_EN
  assign tgt_ok = 1'b1;
  assign drop_stb = 1'b0;
`else
  assign tgt_ok = hit || free;
  assign drop_stb = commit && cmd_on && !tgt_ok;
`endif
  assign alloc = commit && cmd_on && tgt_ok;
  assign off = commit && !cmd_on && hit;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx <= '0;
      hit <= 1'b0;
      hit_idx <= '0;
      free <= 1'b0;
      free_idx <= '0;
      cmd_on <= 1'b0;
      cmd_note <= '0;
      cmd_inc <= '0;
      cmd_wave <= '0;
    end else if (state == IDLE) begin
      if (note_on_stb || note_off_stb) begin
        cmd_on <= note_on_stb;
        cmd_note <= note_num;
        cmd_inc <= note_inc;
        cmd_wave <= note_wave;
        scan_idx <= '0;
        hit <= 1'b0;
        free <= 1'b0;
      end
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + 1'b1;
      if (active[scan_idx] && note[scan_idx] == cmd_note && !hit) begin
        hit <= 1'b1;
        hit_idx <= scan_idx;
      end
      if (!active[scan_idx] && !free) begin
        free <= 1'b1;
        free_idx <= scan_idx;
      end
    end
  end
  assign upd = active[slot] ? acc[slot] + ACC_W'(inc[slot]) : '0;
  // the allocation write comes last so it wins over this cycle's slot update
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
      active <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        acc[i] <= '0;
        inc[i] <= '0;
        wave[i] <= '0;
        note[i] <= '0;
      end
    end else begin
      slot <= slot + 1'b1;
      acc[slot] <= upd;
      if (off) active[hit_idx] <= 1'b0;
      if (alloc) begin
        active[tgt] <= 1'b1;
        acc[tgt] <= '0;
        inc[tgt] <= cmd_inc;
        wave[tgt] <= cmd_wave;
        note[tgt] <= cmd_note;
      end
    end
  end
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tdm_voice_num <= '0;
      tdm_addr <= '0;
      tdm_wavesel <= '0;
      tdm_voice_en <= 1'b0;
      tdm_frame_start <= 1'b0;
    end else begin
      tdm_voice_num <= slot;
      tdm_addr <= upd[ACC_W-1 -: ADDR_W];
      tdm_wavesel <= wave[slot];
      tdm_voice_en <= active[slot];
      tdm_frame_start <= (slot == '0);
    end
  end
  assign voices_active = active;
  voice_lru #(.NUM_VOICES(NUM_VOICES)) u_lru (
    .clk(sys_clk),
    .rst_n(rst_n),
    .alloc(alloc),
    .alloc_idx(tgt),
    .oldest(oldest)
  );
endmodule
